// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion sequencer: drives an external G/key-schedule
// transform round by round and serves the 11 round keys on a read port.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start,key_in  expansion request and cipher key (accepted in IDLE)
//   busy,done     expansion in progress / one-cycle completion pulse
//   keys_valid    buffer holds the full key set of the last accepted key
//   xf_roundkey   transform roundkey input
//   xf_rc         transform RC input
//   xf_subkey     transform output, valid XFORM_LAT cycles after inputs
//   rk_idx        round-key read index
//   rk_out        registered round key
//   rk_err        registered with rk_out: index out of range
//
// Optional: define KEYEXP_REUSE_EN to skip expansion when the same key
// is requested again while the buffer already holds its key set.
module key_expand_ctrl #(
  parameter int XFORM_LAT  = 2,
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  output logic [KEY_W-1:0] xf_roundkey,
  output logic [7:0]       xf_rc,
  input  logic [KEY_W-1:0] xf_subkey,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out,
  output logic             rk_err
);

  localparam int CNT_W =
    (XFORM_LAT > 1) ? $clog2(XFORM_LAT) : 1;
  localparam int RND_W = $clog2(NUM_ROUNDS + 1);

  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(XFORM_LAT - 1);
  localparam logic [RND_W-1:0] LAST_RND =
    RND_W'(NUM_ROUNDS);
  localparam logic [3:0] LAST_IDX =
    4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t           state;
  logic [RND_W-1:0] round;
  logic [CNT_W-1:0] cnt;

  logic [KEY_W-1:0] key_buf [0:NUM_ROUNDS];

  logic reuse_hit;
  logic idx_bad;
  logic last_rnd;
  logic load_key;
  logic capt_key;

  // GF(2^8) doubling: next RCON value.
  function automatic logic [7:0] rc_next(
    input logic [7:0] rc
  );
    return {rc[6:0], 1'b0} ^
           (rc[7] ? 8'h1B : 8'h00);
  endfunction

`ifdef KEYEXP_REUSE_EN
  assign reuse_hit = keys_valid &&
                     (key_in == key_buf[0]);
`else
  assign reuse_hit = 1'b0;
`endif

  assign last_rnd = (round == LAST_RND);
  assign idx_bad  = (rk_idx > LAST_IDX);

  assign load_key = (state == S_IDLE) && start &&
                    !reuse_hit;
  assign capt_key = (state == S_CAPT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      round       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      keys_valid  <= 1'b0;
      xf_roundkey <= '0;
      xf_rc       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (reuse_hit) begin
              state <= S_DONE;
            end else begin
              xf_roundkey <= key_in;
              xf_rc       <= 8'h01;
              round       <= RND_W'(1);
              cnt         <= '0;
              keys_valid  <= 1'b0;
              busy        <= 1'b1;
              state       <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAT_M1) state <= S_CAPT;
        end
        S_CAPT: begin
          xf_roundkey <= xf_subkey;
          if (last_rnd) begin
            // RCON is not advanced past the last
            // round; the RC bus idles at zero.
            xf_rc <= 8'h00;
            state <= S_DONE;
          end else begin
            xf_rc <= rc_next(xf_rc);
            round <= round + 1'b1;
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          keys_valid <= 1'b1;
          xf_rc      <= 8'h00;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Key storage is never cleared; keys_valid
  // qualifies its contents.
  always_ff @(posedge clk) begin
    if (rst_n && load_key) key_buf[0] <= key_in;
    if (rst_n && capt_key) key_buf[round] <= xf_subkey;
  end

  // Read-before-write: a read of the slot being
  // captured this cycle returns its old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_out <= '0;
      rk_err <= 1'b0;
    end else begin
      rk_err <= idx_bad;
      rk_out <= idx_bad ? '0 : key_buf[rk_idx];
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed bench for key_expand_ctrl with a behavioural
// 2-cycle AES key-schedule transform attached.
module tb_key_expand_ctrl;

  localparam logic [127:0] K_FIPS =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS_1 =
    128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPS_10 =
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ZERO = '0;
  localparam logic [127:0] K_ZERO_1 =
    128'h62636363626363636263636362636363;
  localparam logic [127:0] K_ZERO_10 =
    128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  localparam logic [127:0] SBOX [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef KEYEXP_REUSE_EN
  localparam int REP_LAT  = 1;
  localparam bit REP_BUSY = 1'b0;
`else
  localparam int REP_LAT  = 31;
  localparam bit REP_BUSY = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [127:0] xf_roundkey;
  logic [7:0]   xf_rc;
  logic [127:0] xf_subkey;
  logic [3:0]   rk_idx = '0;
  logic [127:0] rk_out;
  logic         rk_err;

  int checks = 0;
  int errors = 0;

  key_expand_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .busy        (busy),
    .done        (done),
    .keys_valid  (keys_valid),
    .xf_roundkey (xf_roundkey),
    .xf_rc       (xf_rc),
    .xf_subkey   (xf_subkey),
    .rk_idx      (rk_idx),
    .rk_out      (rk_out),
    .rk_err      (rk_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    logic [31:0]  s;
    logic [7:0]   b;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      r = SBOX[b[7:4]];
      s[8*i +: 8] = r[127 - 8*b[3:0] -: 8];
    end
    return s;
  endfunction

  function automatic logic [127:0] g_step(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Transform stand-in: two register stages.
  logic [127:0] xf_s1, xf_s2;
  always @(posedge clk) begin
    xf_s1 <= g_step(xf_roundkey, xf_rc);
    xf_s2 <= xf_s1;
  end
  assign xf_subkey = xf_s2;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic read_key(
    input logic [3:0]   idx,
    input logic [127:0] exp,
    input string        tag
  );
    rk_idx = idx;
    @(posedge clk);
    #1;
    check(tag, rk_out, exp);
    check({tag, "_err"}, 128'(rk_err), 128'(0));
  endtask

  // Starts an expansion at the next edge (cycle 0) and
  // watches 45 cycles; lat = first done cycle or -1.
  task automatic run_expand(
    input  logic [127:0] key,
    input  bit           pulse,
    input  bit           chk_rc,
    input  bit           exp_busy,
    output int           lat,
    output int           ndone
  );
    logic [7:0] rcs [30];
    lat   = -1;
    ndone = 0;
    start  = 1'b1;
    key_in = key;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rcs[0] = xf_rc;
    check("busy_c0", 128'(busy), 128'(exp_busy));
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (k < 30) rcs[k] = xf_rc;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      start  = pulse && (k == 5 || k == 20);
      key_in = start ? K_FIPS : key;
    end
    start = 1'b0;
    if (chk_rc)
      for (int k = 0; k < 30; k++)
        check($sformatf("rc_c%0d", k),
              128'(rcs[k]), 128'(RCON[k/3]));
  endtask

  int lat, nd;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_kv", 128'(keys_valid), 128'(0));
    check("rst_xfkey", xf_roundkey, 128'(0));
    check("rst_xfrc", 128'(xf_rc), 128'(0));
    check("rst_rkout", rk_out, 128'(0));
    check("rst_rkerr", 128'(rk_err), 128'(0));
    rst_n  = 1'b1;
    rk_idx = 4'd11;
    @(posedge clk);
    #1;
    check("idx11_err", 128'(rk_err), 128'(1));
    check("idx11_out", rk_out, 128'(0));

    run_expand(K_FIPS, 1'b0, 1'b1, 1'b1, lat, nd);
    check("fips_lat", 128'(lat), 128'(31));
    check("fips_ndone", 128'(nd), 128'(1));
    check("fips_kv", 128'(keys_valid), 128'(1));
    check("fips_busy", 128'(busy), 128'(0));
    read_key(4'd0, K_FIPS, "fips_rk0");
    read_key(4'd1, K_FIPS_1, "fips_rk1");
    read_key(4'd10, K_FIPS_10, "fips_rk10");

    run_expand(K_ZERO, 1'b1, 1'b0, 1'b1, lat, nd);
    check("ign_lat", 128'(lat), 128'(31));
    check("ign_ndone", 128'(nd), 128'(1));
    read_key(4'd0, K_ZERO, "ign_rk0");
    read_key(4'd1, K_ZERO_1, "ign_rk1");
    read_key(4'd10, K_ZERO_10, "ign_rk10");

    start  = 1'b1;
    key_in = K_FIPS;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_kv", 128'(keys_valid), 128'(0));
    check("abort_rc", 128'(xf_rc), 128'(0));
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("abort_ndone", 128'(nd), 128'(0));
    check("abort_kv2", 128'(keys_valid), 128'(0));

    run_expand(K_FIPS, 1'b0, 1'b0, 1'b1, lat, nd);
    check("restart_lat", 128'(lat), 128'(31));
    check("restart_kv", 128'(keys_valid), 128'(1));
    read_key(4'd10, K_FIPS_10, "restart_rk10");

    run_expand(K_FIPS, 1'b0, 1'b0, REP_BUSY, lat, nd);
    check("repeat_lat", 128'(lat), 128'(REP_LAT));
    check("repeat_ndone", 128'(nd), 128'(1));
    check("repeat_kv", 128'(keys_valid), 128'(1));
    read_key(4'd1, K_FIPS_1, "repeat_rk1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
